// File: rtl/sad_disparity_stream.sv
// sad_disparity_stream
//
// Streaming stereo disparity search. Each accepted transaction delivers one
// KERNEL_WIDTH-tall pixel column from the left and from the right camera. The
// block keeps a short history of recent columns and then steps through the
// candidate disparities 0..MAX_DISP-1, one per clock. For each candidate it
// computes the sum of absolute differences (SAD) over a
// KERNEL_WIDTH x KERNEL_WIDTH window. It tracks the best and second-best cost
// and emits one result per pixel.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous active-high reset
//   left_col_in     left column, element 0 (bits [PIX_W-1:0]) is the top row
//   right_col_in    right column, same ordering
//   hcount_in       column index of the incoming column, 0 marks row start
//   vcount_in       row index, passed through to the result
//   data_valid_in   incoming column is valid
//   ready_out       block can accept a column
//   data_valid_out  one-cycle strobe, all result outputs valid this cycle
//   hcount_out      hcount of the result
//   vcount_out      vcount of the result
//   disparity_out   winning disparity
//   depth_out       depth scaled from the winning disparity
//   cost_out        winning SAD cost (all ones when no candidate was legal)
//   disp_valid_out  at least one candidate disparity was legal
//   confident_out   second-best cost exceeds best by at least UNIQ_MARGIN
//
// Handshake: a column transfers on a rising clock edge where data_valid_in and
// ready_out are both high. ready_out is high in IDLE and in the EMIT cycle, and
// low for the whole search. While ready_out is low, data_valid_in is ignored,
// so the source must keep presenting the same column until it is taken.
module sad_disparity_stream #(
    parameter int KERNEL_WIDTH = 3,
    parameter int MAX_DISP     = 16,
    parameter int PIX_W        = 8,
    parameter int UNIQ_MARGIN  = 8,
    parameter int DEPTH_MAX    = 255,
    localparam int COST_W      = PIX_W + $clog2(KERNEL_WIDTH*KERNEL_WIDTH+1),
    localparam int DISP_W      = $clog2(MAX_DISP)
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [KERNEL_WIDTH*PIX_W-1:0] left_col_in,
    input  logic [KERNEL_WIDTH*PIX_W-1:0] right_col_in,
    input  logic [10:0]                   hcount_in,
    input  logic [9:0]                    vcount_in,
    input  logic                          data_valid_in,
    output logic                          ready_out,
    output logic                          data_valid_out,
    output logic [10:0]                   hcount_out,
    output logic [9:0]                    vcount_out,
    output logic [DISP_W-1:0]             disparity_out,
    output logic [7:0]                    depth_out,
    output logic [COST_W-1:0]             cost_out,
    output logic                          disp_valid_out,
    output logic                          confident_out
);

    localparam int RCOLS = KERNEL_WIDTH + MAX_DISP - 1;
    localparam int NL_W  = $clog2(MAX_DISP + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    // The full FSM context (state plus candidate counter) lives in one struct,
    // so a checker can bind to a single signal to observe it.
    typedef struct packed {
        state_t              state;
        logic [DISP_W-1:0]   cand;
    } fsm_t;

    fsm_t fsm_q, fsm_d;

    // Column caches, indexed [column age][row]; age 0 is the newest column.
    logic [PIX_W-1:0] left_cache  [KERNEL_WIDTH][KERNEL_WIDTH];
    logic [PIX_W-1:0] right_cache [RCOLS][KERNEL_WIDTH];

    logic [10:0]       h_lat;
    logic [9:0]        v_lat;
    logic [COST_W-1:0] best_q, second_q;
    logic [DISP_W-1:0] best_d_q;
    logic [NL_W-1:0]   n_legal_q;

    logic              xfer;
    logic              row_start;
    logic              last_cand;
    logic              cand_legal;
    logic [COST_W-1:0] cand_cost;
    logic [PIX_W-1:0]  rpix;
    logic [PIX_W:0]    diff;
    logic [PIX_W:0]    diff_neg;
    logic [PIX_W-1:0]  absd;

    logic [COST_W-1:0] best_n, second_n;
    logic [DISP_W-1:0] best_d_n;
    logic [NL_W-1:0]   n_legal_n;

    logic [7:0] depth_table [MAX_DISP];

    // Constant lookup: depth grows linearly with disparity, reaching DEPTH_MAX
    // at the largest candidate.
    for (genvar i = 0; i < MAX_DISP; i++) begin : g_depth
        assign depth_table[i] = 8'((i * DEPTH_MAX) / (MAX_DISP - 1));
    end

    assign xfer      = data_valid_in && ready_out;
    assign row_start = (hcount_in == 11'd0);
    assign last_cand = (fsm_q.cand == DISP_W'(MAX_DISP - 1));

    // A candidate is legal only when every right column it would compare
    // against lies inside the current row.
    assign cand_legal = (int'(h_lat) >= KERNEL_WIDTH - 1 + int'(fsm_q.cand));

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fsm_q <= '{state: S_IDLE, cand: '0};
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q.state)
            S_IDLE: begin
                if (xfer) begin
                    fsm_d.state = S_SEARCH;
                    fsm_d.cand  = '0;
                end
            end
            S_SEARCH: begin
                if (last_cand) begin
                    fsm_d.state = S_EMIT;
                    fsm_d.cand  = '0;
                end else begin
                    fsm_d.cand = fsm_q.cand + 1'b1;
                end
            end
            S_EMIT: begin
                // A new column may be taken in the same cycle the result leaves.
                if (xfer) begin
                    fsm_d.state = S_SEARCH;
                    fsm_d.cand  = '0;
                end else begin
                    fsm_d.state = S_IDLE;
                end
            end
            default: begin
                fsm_d.state = S_IDLE;
                fsm_d.cand  = '0;
            end
        endcase
    end

    // ---------------------------------------------------- SAD of candidate
    always_comb begin
        cand_cost = '0;
        rpix      = '0;
        diff      = '0;
        diff_neg  = '0;
        absd      = '0;
        for (int c = 0; c < KERNEL_WIDTH; c++) begin
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                // Select right column age c+d with constant indices only.
                rpix = '0;
                for (int dd = 0; dd < MAX_DISP; dd++) begin
                    if (fsm_q.cand == DISP_W'(dd)) begin
                        rpix = right_cache[c + dd][r];
                    end
                end
                diff      = {1'b0, left_cache[c][r]} - {1'b0, rpix};
                diff_neg  = -diff;
                absd      = diff[PIX_W] ? diff_neg[PIX_W-1:0] : diff[PIX_W-1:0];
                cand_cost = cand_cost + COST_W'(absd);
            end
        end
    end

    // ------------------------------------------- best / second-best update
    always_comb begin
        best_n    = best_q;
        second_n  = second_q;
        best_d_n  = best_d_q;
        n_legal_n = n_legal_q;
        if (cand_legal) begin
            n_legal_n = n_legal_q + 1'b1;
            // Strict compares: on a tie the earlier (smaller) disparity keeps
            // the win and the equal cost becomes second best.
            if (cand_cost < best_q) begin
                second_n = best_q;
                best_n   = cand_cost;
                best_d_n = fsm_q.cand;
            end else if (cand_cost < second_q) begin
                second_n = cand_cost;
            end
        end
    end

    // ------------------------------------------- caches and search state
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int c = 0; c < KERNEL_WIDTH; c++) begin
                for (int r = 0; r < KERNEL_WIDTH; r++) begin
                    left_cache[c][r] <= '0;
                end
            end
            for (int c = 0; c < RCOLS; c++) begin
                for (int r = 0; r < KERNEL_WIDTH; r++) begin
                    right_cache[c][r] <= '0;
                end
            end
            h_lat     <= '0;
            v_lat     <= '0;
            best_q    <= '1;
            second_q  <= '1;
            best_d_q  <= '0;
            n_legal_q <= '0;
        end else if (xfer) begin
            // On row start the older history belongs to the previous row, so
            // it is replaced by zeros while the new column shifts in.
            for (int r = 0; r < KERNEL_WIDTH; r++) begin
                left_cache[0][r]  <= left_col_in[r*PIX_W +: PIX_W];
                right_cache[0][r] <= right_col_in[r*PIX_W +: PIX_W];
                for (int c = 1; c < KERNEL_WIDTH; c++) begin
                    left_cache[c][r] <= row_start ? '0 : left_cache[c-1][r];
                end
                for (int c = 1; c < RCOLS; c++) begin
                    right_cache[c][r] <= row_start ? '0 : right_cache[c-1][r];
                end
            end
            h_lat     <= hcount_in;
            v_lat     <= vcount_in;
            best_q    <= '1;
            second_q  <= '1;
            best_d_q  <= '0;
            n_legal_q <= '0;
        end else if (fsm_q.state == S_SEARCH) begin
            best_q    <= best_n;
            second_q  <= second_n;
            best_d_q  <= best_d_n;
            n_legal_q <= n_legal_n;
        end
    end

    // ------------------------------------------------------------ outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_out      <= 1'b1;
            data_valid_out <= 1'b0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            disparity_out  <= '0;
            depth_out      <= '0;
            cost_out       <= '1;
            disp_valid_out <= 1'b0;
            confident_out  <= 1'b0;
        end else begin
            ready_out      <= (fsm_d.state != S_SEARCH);
            data_valid_out <= (fsm_d.state == S_EMIT);
            // The last candidate's update is folded in via the *_n values.
            if (fsm_q.state == S_SEARCH && last_cand) begin
                hcount_out <= h_lat;
                vcount_out <= v_lat;
                if (n_legal_n == '0) begin
                    disp_valid_out <= 1'b0;
                    disparity_out  <= '0;
                    depth_out      <= '0;
                    cost_out       <= '1;
                    confident_out  <= 1'b0;
                end else begin
                    disp_valid_out <= 1'b1;
                    disparity_out  <= best_d_n;
                    depth_out      <= depth_table[best_d_n];
                    cost_out       <= best_n;
                    confident_out  <= (n_legal_n >= NL_W'(2)) &&
                                      ((second_n - best_n) >= COST_W'(UNIQ_MARGIN));
                end
            end
        end
    end

endmodule
